// File: rtl/noise_pkg.sv
// Shared types and constants for the channel noise injector and its LFSR.
package noise_pkg;

   localparam logic [31:0] LFSR_TOGGLE_MASK = 32'h8020_0003;
   localparam int          POS_W            = 5;
   localparam int          STAT_W           = 16;

   typedef enum logic [1:0] {
      MODE_8  = 2'd0,
      MODE_16 = 2'd1,
      MODE_32 = 2'd2
   } work_mode_t;

   typedef enum logic [1:0] {
      NOISE_NONE   = 2'd0,
      NOISE_SINGLE = 2'd1,
      NOISE_DOUBLE = 2'd2,
      NOISE_RANDOM = 2'd3
   } noise_mode_t;

   // Position mask M = L-1; the reserved encoding falls back to a 32-bit word.
   function automatic logic [POS_W-1:0] len_mask(input work_mode_t mode);
      case (mode)
         MODE_8:  return 5'd7;
         MODE_16: return 5'd15;
         default: return 5'd31;
      endcase
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1), advances only when step is high.
module lfsr32
   import noise_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [31:0] state
);

   logic [31:0] state_q;
   logic [31:0] state_next;

   // Right-shifting form: the bit leaving position 0 toggles the tap positions.
   always_comb begin
      state_next = {1'b0, state_q[31:1]};
      if (state_q[0]) begin
         state_next = state_next ^ LFSR_TOGGLE_MASK;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEED;
      end else if (step) begin
         state_q <= state_next;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/channel_noise_injector.sv
// Seed-driven 0/1/2-bit error injector between encoder and decoder.
// Optional statistics counters are built when NOISE_STATS_EN is defined.
module channel_noise_injector
   import noise_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic [1:0]            work_mode,
   input  logic [1:0]            noise_mode,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] flip_mask,
   output logic [1:0]            flip_count,
   output logic [STAT_W-1:0]     word_cnt,
   output logic [STAT_W-1:0]     single_cnt,
   output logic [STAT_W-1:0]     double_cnt
);

   logic [31:0]           lfsr_state;
   logic [POS_W-1:0]      pos_mask;
   logic [POS_W-1:0]      p0;
   logic [POS_W-1:0]      p1_raw;
   logic [POS_W-1:0]      p1;
   logic [1:0]            count_next;
   logic [DATA_WIDTH-1:0] mask_next;

   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [1:0]            count_q;
   logic                  valid_q;

   // The flip decision uses the pre-step value; stepping happens on the same edge.
   lfsr32 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (valid_in),
      .state (lfsr_state)
   );

   always_comb begin
      pos_mask = len_mask(work_mode_t'(work_mode));
      p0       = lfsr_state[4:0] & pos_mask;
      p1_raw   = lfsr_state[12:8] & pos_mask;
      p1       = p1_raw;
      // A collision moves the second flip to the next position, wrapping inside L.
      if (p1_raw == p0) begin
         p1 = (p0 + 5'd1) & pos_mask;
      end
   end

   always_comb begin
      count_next = 2'd0;
      case (noise_mode_t'(noise_mode))
         NOISE_NONE:   count_next = 2'd0;
         NOISE_SINGLE: count_next = 2'd1;
         NOISE_DOUBLE: count_next = 2'd2;
         NOISE_RANDOM: count_next = lfsr_state[17] ? 2'd2 : {1'b0, lfsr_state[16]};
         default:      count_next = 2'd0;
      endcase
   end

   always_comb begin
      mask_next = '0;
      if (count_next != 2'd0) begin
         mask_next[p0] = 1'b1;
      end
      if (count_next == 2'd2) begin
         mask_next[p1] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         mask_q  <= '0;
         count_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_in;
         if (valid_in) begin
            data_q  <= data_in ^ mask_next;
            mask_q  <= mask_next;
            count_q <= count_next;
         end
      end
   end

   assign data_out   = data_q;
   assign flip_mask  = mask_q;
   assign flip_count = count_q;
   assign valid      = valid_q;

`ifdef NOISE_STATS_EN
   logic [STAT_W-1:0] word_q;
   logic [STAT_W-1:0] single_q;
   logic [STAT_W-1:0] double_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q   <= '0;
         single_q <= '0;
         double_q <= '0;
      end else if (valid_in) begin
         word_q <= sat_inc(word_q);
         if (count_next == 2'd1) begin
            single_q <= sat_inc(single_q);
         end
         if (count_next == 2'd2) begin
            double_q <= sat_inc(double_q);
         end
      end
   end

   assign word_cnt   = word_q;
   assign single_cnt = single_q;
   assign double_cnt = double_q;
`else
   assign word_cnt   = '0;
   assign single_cnt = '0;
   assign double_cnt = '0;
`endif

   // Only the position and random-count fields of the LFSR feed the datapath.
   logic unused_lfsr_bits;
   assign unused_lfsr_bits = ^{lfsr_state[31:18], lfsr_state[15:13], lfsr_state[7:5]};

endmodule

// File: tb/tb_channel_noise_injector.sv
// Self-checking bench for channel_noise_injector against a behavioural error-pattern model.
module tb_channel_noise_injector;

   localparam logic [31:0] SEED      = 32'hACE1_2468;
   localparam logic [31:0] SEED_COLL = 32'h0000_0707;
   localparam logic [31:0] POLY      = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        valid_in_c = 1'b0;
   logic [1:0]  work_mode = '0;
   logic [1:0]  noise_mode = '0;

   logic [31:0] data_out, flip_mask;
   logic        valid;
   logic [1:0]  flip_count;
   logic [15:0] word_cnt, single_cnt, double_cnt;

   logic [31:0] data_out_c, flip_mask_c;
   logic        valid_c;
   logic [1:0]  flip_count_c;
   logic [15:0] word_cnt_c, single_cnt_c, double_cnt_c;

   int test_cnt = 0;
   int fail_cnt = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mask_q[$];
   logic [31:0] m_lfsr;
   int          m_words, m_single, m_double;
   logic [31:0] last_data, last_mask;
   logic [1:0]  last_count;
   logic [31:0] first_masks[10];

   channel_noise_injector #(.DATA_WIDTH(32), .LFSR_SEED(SEED)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .work_mode(work_mode), .noise_mode(noise_mode),
      .data_out(data_out), .valid(valid), .flip_mask(flip_mask), .flip_count(flip_count),
      .word_cnt(word_cnt), .single_cnt(single_cnt), .double_cnt(double_cnt)
   );

   channel_noise_injector #(.DATA_WIDTH(32), .LFSR_SEED(SEED_COLL)) u_dut_coll (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in_c),
      .work_mode(work_mode), .noise_mode(noise_mode),
      .data_out(data_out_c), .valid(valid_c), .flip_mask(flip_mask_c), .flip_count(flip_count_c),
      .word_cnt(word_cnt_c), .single_cnt(single_cnt_c), .double_cnt(double_cnt_c)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_step(input logic [31:0] s);
      logic [31:0] n;
      n = s / 2;
      if (s % 2 == 1) n = n ^ POLY;
      return n;
   endfunction

   function automatic logic [31:0] model_mask(input logic [31:0] s, input logic [1:0] wm,
                                              input logic [1:0] nm);
      int len, p0, p1, n, r;
      logic [31:0] m;
      len = (wm == 2'd0) ? 8 : (wm == 2'd1) ? 16 : 32;
      p0  = int'(s % 32) % len;
      p1  = int'((s / 256) % 32) % len;
      if (p1 == p0) p1 = (p0 + 1) % len;
      r = int'((s / 65536) % 4);
      case (nm)
         2'd0:    n = 0;
         2'd1:    n = 1;
         2'd2:    n = 2;
         default: n = (r >= 2) ? 2 : r;
      endcase
      m = 32'h0;
      if (n >= 1) m = m | (32'h1 << p0);
      if (n == 2) m = m | (32'h1 << p1);
      return m;
   endfunction

   function automatic logic [15:0] exp_stat(input int v);
`ifdef NOISE_STATS_EN
      return (v > 65535) ? 16'hFFFF : 16'(v);
`else
      return (v >= 0) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic reset_dut();
      @(negedge clk);
      valid_in   = 1'b0;
      valid_in_c = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      m_lfsr    = SEED;
      m_words   = 0;
      m_single  = 0;
      m_double  = 0;
      last_data = '0;
      last_mask = '0;
      last_count = '0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic [1:0] wm, input logic [1:0] nm);
      logic [31:0] m;
      @(negedge clk);
      data_in    = d;
      work_mode  = wm;
      noise_mode = nm;
      valid_in   = 1'b1;
      m = model_mask(m_lfsr, wm, nm);
      exp_q.push_back(d ^ m);
      mask_q.push_back(m);
      m_lfsr = model_step(m_lfsr);
      m_words++;
      if ($countones(m) == 1) m_single++;
      if ($countones(m) == 2) m_double++;
      @(posedge clk);
      #1;
      check("valid", {31'b0, valid}, 32'h1);
      check("data_out", data_out, exp_q.pop_front());
      check("flip_mask", flip_mask, mask_q.pop_front());
      check("flip_count", {30'b0, flip_count}, 32'($countones(m)));
      check("word_cnt", {16'b0, word_cnt}, {16'b0, exp_stat(m_words)});
      check("single_cnt", {16'b0, single_cnt}, {16'b0, exp_stat(m_single)});
      check("double_cnt", {16'b0, double_cnt}, {16'b0, exp_stat(m_double)});
      last_data  = d ^ m;
      last_mask  = m;
      last_count = 2'($countones(m));
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = $urandom;
      @(posedge clk);
      #1;
      check("idle_valid", {31'b0, valid}, 32'h0);
      check("idle_data_hold", data_out, last_data);
      check("idle_mask_hold", flip_mask, last_mask);
      check("idle_count_hold", {30'b0, flip_count}, {30'b0, last_count});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] d;
      logic [1:0]  wm, nm;

      // Reset state
      #3;
      check("rst_data_out", data_out, 32'h0);
      check("rst_flip_mask", flip_mask, 32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_word_cnt", {16'b0, word_cnt}, 32'h0);
      reset_dut();

      // Collision wrap on the second instance: p0 = p1 = 7 in an 8-bit word
      @(negedge clk);
      data_in = 32'h0; work_mode = 2'd0; noise_mode = 2'd2; valid_in_c = 1'b1;
      @(posedge clk);
      #1;
      check("coll_mask", flip_mask_c, 32'h0000_0081);
      check("coll_data", data_out_c, 32'h0000_0081);
      check("coll_count", {30'b0, flip_count_c}, 32'h2);
      check("coll_valid", {31'b0, valid_c}, 32'h1);
      @(negedge clk);
      valid_in_c = 1'b0;

      // Pass-through
      reset_dut();
      send_word(32'h1234_5678, 2'd2, 2'd0);
      check("pass_data", data_out, 32'h1234_5678);
      check("pass_mask", flip_mask, 32'h0);
      idle_cycle();

      // Reference run of 10 double-flip words straight after reset
      reset_dut();
      for (int i = 0; i < 10; i++) begin
         first_masks[i] = model_mask(m_lfsr, 2'd2, 2'd2);
         send_word($urandom, 2'd2, 2'd2);
      end

      // Reset during word 5 of 10, then replay
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         send_word($urandom, 2'd2, 2'd2);
         check("pre_rst_mask", flip_mask, first_masks[i]);
      end
      @(negedge clk);
      data_in = $urandom; valid_in = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, valid}, 32'h0);
      check("midrst_data", data_out, 32'h0);
      check("midrst_mask", flip_mask, 32'h0);
      check("midrst_count", {30'b0, flip_count}, 32'h0);
      check("midrst_word_cnt", {16'b0, word_cnt}, 32'h0);
      @(negedge clk);
      valid_in = 1'b0;
      rst = 1'b0;
      m_lfsr = SEED; m_words = 0; m_single = 0; m_double = 0;
      for (int i = 0; i < 10; i++) begin
         send_word($urandom, 2'd2, 2'd2);
         check("replay_mask", flip_mask, first_masks[i]);
      end

      // Statistics: 10 single then 5 double
      reset_dut();
      for (int i = 0; i < 10; i++) send_word($urandom, 2'($urandom_range(0, 3)), 2'd1);
      for (int i = 0; i < 5; i++) send_word($urandom, 2'($urandom_range(0, 3)), 2'd2);
`ifdef NOISE_STATS_EN
      check("stats_word", {16'b0, word_cnt}, 32'd15);
      check("stats_single", {16'b0, single_cnt}, 32'd10);
      check("stats_double", {16'b0, double_cnt}, 32'd5);
`else
      check("stats_word_off", {16'b0, word_cnt}, 32'd0);
      check("stats_single_off", {16'b0, single_cnt}, 32'd0);
      check("stats_double_off", {16'b0, double_cnt}, 32'd0);
`endif

      // Single flip in 8-bit words
      for (int i = 0; i < 200; i++) begin
         send_word(32'hFFFF_FF00, 2'd0, 2'd1);
         check("s8_popcount", 32'($countones(flip_mask)), 32'd1);
         check("s8_mask_range", flip_mask & 32'hFFFF_FF00, 32'h0);
         check("s8_upper", data_out & 32'hFFFF_FF00, 32'hFFFF_FF00);
      end

      // Double flip, 1000 back-to-back 32-bit words
      for (int i = 0; i < 1000; i++) begin
         send_word($urandom, 2'd2, 2'd2);
         check("d32_popcount", 32'($countones(flip_mask)), 32'd2);
      end

      // Random modes with occasional idle cycles
      for (int i = 0; i < 300; i++) begin
         d  = $urandom;
         wm = 2'($urandom_range(0, 3));
         nm = 2'($urandom_range(0, 3));
         send_word(d, wm, nm);
         if ($urandom_range(0, 4) == 0) idle_cycle();
      end
      idle_cycle();

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
